// File: rtl/caravel_wb_port_pkg.sv
// caravel_wb_port_pkg: shared register offsets, ID value and pad reset values
// Offsets are word offsets, i.e. byte address bits [11:2].
package caravel_wb_port_pkg;
    localparam logic [9:0]  OFF_OUT_LO = 10'h040;
    localparam logic [9:0]  OFF_OUT_HI = 10'h041;
    localparam logic [9:0]  OFF_OEB_LO = 10'h042;
    localparam logic [9:0]  OFF_OEB_HI = 10'h043;
    localparam logic [9:0]  OFF_ID     = 10'h044;
    localparam logic [31:0] ID_VAL     = 32'h5742_0001;
    localparam logic [37:0] OEB_RST    = {38{1'b1}};
endpackage

// File: rtl/wb_byte_reg.sv
// wb_byte_reg: 32-bit register with per-byte write enables and a reset value
// Ports: clk_i clock, rst_i sync active-high reset, be_i byte enables,
//        d_i write data, q_o current value.
module wb_byte_reg #(
    parameter logic [31:0] RST = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);
    logic [31:0] q_q, q_d;
    always_comb begin
        q_d = q_q;
        for (int b = 0; b < 4; b++) q_d[b*8 +: 8] = be_i[b] ? d_i[b*8 +: 8] : q_q[b*8 +: 8];
    end
    always_ff @(posedge clk_i) q_q <= rst_i ? RST : q_d;
    assign q_o = q_q;
endmodule

// File: rtl/caravel_wb_port.sv
// caravel_wb_port: Wishbone slave with scratch registers and GPIO pad out/oeb registers
// Ports: wb_clk_i/wb_rst_i clock and sync reset; wbs_* Wishbone slave bus
//        (one wait state, registered ack and read data); io_out/io_oeb pad drive.
module caravel_wb_port
    import caravel_wb_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NREGS     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);
    localparam int         IW = NREGS > 1 ? $clog2(NREGS) : 1;
    localparam logic [9:0] NR = 10'(NREGS);
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d, rdata;
    logic [31:0] out_lo, out_hi, oeb_lo, oeb_hi;
    logic [31:0] scr [NREGS];
    logic [9:0]  off;
    logic        req, wr, unused_ok;
    assign off       = wbs_adr_i[11:2];
    assign unused_ok = ^wbs_adr_i[1:0];
    // ~ack_q forces an idle cycle after each ack so a held strobe is not double-accepted
    assign req = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign wr  = req & wbs_we_i;
    for (genvar g = 0; g < NREGS; g++) begin : g_scr
        wb_byte_reg u_scr (
            .clk_i(wb_clk_i), .rst_i(wb_rst_i),
            .be_i(wr && off == 10'(g) ? wbs_sel_i : 4'b0),
            .d_i(wbs_dat_i), .q_o(scr[g])
        );
    end
    wb_byte_reg u_out_lo (
        .clk_i(wb_clk_i), .rst_i(wb_rst_i),
        .be_i(wr && off == OFF_OUT_LO ? wbs_sel_i : 4'b0),
        .d_i(wbs_dat_i), .q_o(out_lo)
    );
    // HI registers take only bits [5:0]; upper bits stay 0 so readback needs no mask
    wb_byte_reg u_out_hi (
        .clk_i(wb_clk_i), .rst_i(wb_rst_i),
        .be_i(wr && off == OFF_OUT_HI ? wbs_sel_i : 4'b0),
        .d_i({26'h0, wbs_dat_i[5:0]}), .q_o(out_hi)
    );
    wb_byte_reg #(.RST(OEB_RST[31:0])) u_oeb_lo (
        .clk_i(wb_clk_i), .rst_i(wb_rst_i),
        .be_i(wr && off == OFF_OEB_LO ? wbs_sel_i : 4'b0),
        .d_i(wbs_dat_i), .q_o(oeb_lo)
    );
    wb_byte_reg #(.RST({26'h0, OEB_RST[37:32]})) u_oeb_hi (
        .clk_i(wb_clk_i), .rst_i(wb_rst_i),
        .be_i(wr && off == OFF_OEB_HI ? wbs_sel_i : 4'b0),
        .d_i({26'h0, wbs_dat_i[5:0]}), .q_o(oeb_hi)
    );
    always_comb begin
        rdata = off < NR          ? scr[off[IW-1:0]] :
                off == OFF_OUT_LO ? out_lo :
                off == OFF_OUT_HI ? out_hi :
                off == OFF_OEB_LO ? oeb_lo :
                off == OFF_OEB_HI ? oeb_hi :
                off == OFF_ID     ? ID_VAL : 32'h0;
        ack_d = req;
        dat_d = req && !wbs_we_i ? rdata : 32'h0;
    end
    always_ff @(posedge wb_clk_i) begin
        ack_q <= wb_rst_i ? 1'b0 : ack_d;
        dat_q <= wb_rst_i ? 32'h0 : dat_d;
    end
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = {out_hi[5:0], out_lo};
    assign io_oeb    = {oeb_hi[5:0], oeb_lo};
endmodule

// File: tb/tb_caravel_wb_port.sv
// tb_caravel_wb_port: directed vector bench for caravel_wb_port
module tb_caravel_wb_port;
    logic        clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, wdat = 0;
    logic        ack;
    logic [31:0] rdat;
    logic [37:0] io_out, io_oeb;
    int          checks = 0, errors = 0;

    localparam logic [31:0] ID  = 32'h5742_0001;
    localparam logic [37:0] OB1 = 38'h3F_FFFF_FFFF;

    caravel_wb_port dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat), .io_out(io_out), .io_oeb(io_oeb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] d;
        logic        ack;
        logic [31:0] rd;
        logic [37:0] out;
        logic [37:0] oeb;
    } vec_t;
    vec_t v[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // drive a request at a negedge, wait up to 8 cycles for ack, then one idle cycle
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic got_ack, output logic [31:0] rd, output int lat);
        cyc = 1; stb = 1; we = w; adr = a; sel = s; wdat = d;
        got_ack = 0; rd = 0; lat = 0;
        for (int i = 1; i <= 8 && !got_ack; i++) begin
            @(negedge clk);
            if (ack) begin got_ack = 1; rd = rdat; lat = i; end
        end
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
    endtask

    function automatic vec_t mk(logic w, logic [31:0] a, logic [3:0] s, logic [31:0] d,
                                logic k, logic [31:0] r, logic [37:0] o, logic [37:0] e);
        vec_t t;
        t.we = w; t.adr = a; t.sel = s; t.d = d; t.ack = k; t.rd = r; t.out = o; t.oeb = e;
        return t;
    endfunction

    logic        ga;
    logic [31:0] gr;
    int          gl;

    initial begin
        v.push_back(mk(0, 32'h3000_0110, 4'hF, 0,            1, ID,           0,               OB1));
        v.push_back(mk(1, 32'h3000_0108, 4'hF, 32'h0000_FFFF, 1, 0,            0,               38'h3F_0000_FFFF));
        v.push_back(mk(1, 32'h3000_0100, 4'hF, 32'hAB60_0000, 1, 0,            38'h00_AB60_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(1, 32'h3000_0100, 4'hF, 32'hAB61_0000, 1, 0,            38'h00_AB61_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(1, 32'h3000_0000, 4'hF, 32'hDEAD_BEEF, 1, 0,            38'h00_AB61_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(0, 32'h3000_0000, 4'hF, 0,            1, 32'hDEAD_BEEF, 38'h00_AB61_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(1, 32'h3000_0000, 4'h5, 32'h1122_3344, 1, 0,            38'h00_AB61_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(0, 32'h3000_0000, 4'hF, 0,            1, 32'hDE22_BE44, 38'h00_AB61_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(1, 32'h3000_0200, 4'hF, 32'h1234_5678, 1, 0,            38'h00_AB61_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(0, 32'h3000_0200, 4'hF, 0,            1, 0,            38'h00_AB61_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(1, 32'h3100_0000, 4'hF, 32'hFFFF_FFFF, 0, 0,            38'h00_AB61_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(0, 32'h3000_0000, 4'hF, 0,            1, 32'hDE22_BE44, 38'h00_AB61_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(1, 32'h3000_0104, 4'hF, 32'hFFFF_FFFF, 1, 0,            38'h3F_AB61_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(0, 32'h3000_0104, 4'hF, 0,            1, 32'h0000_003F, 38'h3F_AB61_0000, 38'h3F_0000_FFFF));
        v.push_back(mk(1, 32'h3000_010C, 4'hF, 32'h0,         1, 0,            38'h3F_AB61_0000, 38'h00_0000_FFFF));
        v.push_back(mk(0, 32'h3000_010C, 4'hF, 0,            1, 0,            38'h3F_AB61_0000, 38'h00_0000_FFFF));
        v.push_back(mk(1, 32'h3000_0110, 4'hF, 32'h0,         1, 0,            38'h3F_AB61_0000, 38'h00_0000_FFFF));
        v.push_back(mk(0, 32'h3000_0110, 4'hF, 0,            1, ID,           38'h3F_AB61_0000, 38'h00_0000_FFFF));
        v.push_back(mk(1, 32'h3000_003C, 4'h0, 32'hFFFF_FFFF, 1, 0,            38'h3F_AB61_0000, 38'h00_0000_FFFF));
        v.push_back(mk(0, 32'h3000_003C, 4'hF, 0,            1, 0,            38'h3F_AB61_0000, 38'h00_0000_FFFF));
        v.push_back(mk(1, 32'h3000_003C, 4'h8, 32'hA5FF_FFFF, 1, 0,            38'h3F_AB61_0000, 38'h00_0000_FFFF));
        v.push_back(mk(0, 32'h3000_003F, 4'h0, 0,            1, 32'hA500_0000, 38'h3F_AB61_0000, 38'h00_0000_FFFF));
        v.push_back(mk(1, 32'h3000_0040, 4'hF, 32'hFFFF_FFFF, 1, 0,            38'h3F_AB61_0000, 38'h00_0000_FFFF));
        v.push_back(mk(0, 32'h3000_0040, 4'hF, 0,            1, 0,            38'h3F_AB61_0000, 38'h00_0000_FFFF));
        v.push_back(mk(0, 32'h3000_0108, 4'hF, 0,            1, 32'h0000_FFFF, 38'h3F_AB61_0000, 38'h00_0000_FFFF));
        v.push_back(mk(0, 32'h3000_0100, 4'hF, 0,            1, 32'hAB61_0000, 38'h3F_AB61_0000, 38'h00_0000_FFFF));

        repeat (4) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_out", io_out, 0);
        chk("rst_oeb", io_oeb, OB1);
        rst = 0;
        @(negedge clk);

        foreach (v[i]) begin
            bus(v[i].we, v[i].adr, v[i].sel, v[i].d, ga, gr, gl);
            chk($sformatf("v%0d_ack", i), ga, v[i].ack);
            if (v[i].ack) chk($sformatf("v%0d_lat", i), gl, 1);
            if (v[i].ack && !v[i].we) chk($sformatf("v%0d_rd", i), gr, v[i].rd);
            chk($sformatf("v%0d_out", i), io_out, v[i].out);
            chk($sformatf("v%0d_oeb", i), io_oeb, v[i].oeb);
        end

        // strobe held high for three transfers: ack alternates, data only in ack cycles
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0110; sel = 4'hF;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b2b_ack%0d", k), ack, k % 2);
            chk($sformatf("b2b_dat%0d", k), rdat, (k % 2) ? ID : 32'h0);
            @(negedge clk);
        end
        cyc = 0; stb = 0;
        @(negedge clk);

        // strobe dropped before the accepting edge: no ack, no write
        cyc = 1; stb = 1; we = 1; adr = 32'h3000_0008; sel = 4'hF; wdat = 32'hCAFE_F00D;
        #2 stb = 0; cyc = 0; we = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("drop_ack%0d", k), ack, 0);
        end
        bus(0, 32'h3000_0008, 4'hF, 0, ga, gr, gl);
        chk("drop_rd", gr, 0);

        // reset asserted on the accept edge, request held across release
        rst = 1; cyc = 1; stb = 1; we = 1; adr = 32'h3000_0100; sel = 4'hF; wdat = 32'h1234_5678;
        @(negedge clk);
        chk("rstw_ack", ack, 0);
        chk("rstw_out", io_out, 0);
        chk("rstw_oeb", io_oeb, OB1);
        rst = 0;
        @(negedge clk);
        chk("rel_ack", ack, 1);
        chk("rel_out", io_out, 38'h00_1234_5678);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        bus(0, 32'h3000_0000, 4'hF, 0, ga, gr, gl);
        chk("rstw_scr0", gr, 0);
        bus(0, 32'h3000_003C, 4'hF, 0, ga, gr, gl);
        chk("rstw_scr15", gr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/caravel_wb_port.md
# caravel_wb_port

User-project Wishbone slave for the Caravel harness. The management SoC reaches it at the user-area base address; it provides a bank of scratch registers for read/write checks, plus output and output-enable registers that drive the user GPIO pads `mprj_io[37:0]`. Firmware uses it to signal test progress, for example the value 0xAB60 followed by 0xAB61 on pads [31:16].

## Interface

Parameters:
- `BASE_ADDR`, default 32'h3000_0000: base of the 4 KiB decode window.
- `NREGS`, default 16: number of 32-bit scratch registers (power of two, at most 64).

Ports:
- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `wbs_cyc_i`  in  1  bus cycle.
- `wbs_stb_i`  in  1  strobe.
- `wbs_we_i`  in  1  write enable.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  read data.
- `io_out`  out  38  pad output values.
- `io_oeb`  out  38  pad output-enable, active low.

## Operation

- **Window select.** A request is selected when `wbs_adr_i[31:12] == BASE_ADDR[31:12]`. The register offset is `wbs_adr_i[11:2]`; `adr[1:0]` is ignored.
- **Register map (byte offsets):**
  - 0x000 to 4*(NREGS-1): scratch registers, R/W.
  - 0x100 OUT_LO: R/W, drives `io_out[31:0]`.
  - 0x104 OUT_HI: R/W, bits [5:0] drive `io_out[37:32]`; bits [31:6] read 0.
  - 0x108 OEB_LO: R/W, drives `io_oeb[31:0]`.
  - 0x10C OEB_HI: R/W, bits [5:0] drive `io_oeb[37:32]`; bits [31:6] read 0.
  - 0x110 ID: read-only, returns 32'h5742_0001. Writes are ignored.
  - Any other offset inside the window: reads 0, writes are ignored, and the request is still acknowledged.
- **Writes.** Byte lane n is updated only when `wbs_sel_i[n]` = 1. When `sel` = 0, the register is unchanged but the request is still acknowledged.
- **Reads.** Reads ignore `sel` and always return the full 32-bit word.
- **Outside the window.** No ack is issued and no state changes. The requester is expected to time out.

## Timing

- **Accept.** A request is accepted when `cyc & stb & ~ack` is high at a rising edge while the window is selected.
- **Ack.** `wbs_ack_o` goes high on the next edge and stays high for exactly one cycle. Latency is therefore 1 wait state; the ack is visible in the cycle after the request.
- **Write commit.** The write takes effect on the same edge that raises `ack`. `io_out`/`io_oeb` show the new value from that edge onward.
- **Read data.** `wbs_dat_o` is registered and valid while `ack` is high. It returns 0 in all other cycles.
- **Back-to-back.** If `stb` stays high after an ack, the next request is accepted on the following edge. Throughput is one transfer per two cycles, and `ack` never stays high for two consecutive cycles.
- **Dropped requests.** If `cyc` or `stb` drops before the ack, the request is abandoned: no ack and no write.
- **Reset values** (while `wb_rst_i` is high at an edge):
  - `wbs_ack_o` = 0, `wbs_dat_o` = 0.
  - Scratch registers = 0.
  - `io_out` = 0.
  - `io_oeb` = all 1s (all pads input).
- **Reset mid-transaction.** Any pending ack is cancelled and any write not yet committed is discarded. A request held across the release of reset is accepted on the first edge after release.

## Structure

- **Shared package `caravel_wb_port_pkg`** holds:
  - the offset constants OFF_OUT_LO, OFF_OUT_HI, OFF_OEB_LO, OFF_OEB_HI, OFF_ID;
  - the ID value;
  - the reset value of `io_oeb`.
- **Sub-module `wb_byte_reg`**: a 32-bit register with per-byte write enables and a reset value, instantiated for every R/W register.
- **Top level** contains the decode, ack, and read-mux logic.

## Test plan

- **Reset values.** Hold reset 4 cycles → `io_oeb` = all 1s, `io_out` = 0, `ack` = 0. Read 0x3000_0110 → 0x5742_0001 with 1-cycle ack latency.
- **Progress signal.** Write OEB_LO = 0x0000_FFFF, then OUT_LO = 0xAB60_0000 → `io_out[31:16]` = 0xAB60 and `io_oeb[31:16]` = 0. Then write OUT_LO = 0xAB61_0000 → pads [31:16] show 0xAB61.
- **Scratch and byte enables.** Write 0xDEAD_BEEF to offset 0x00, then read back → 0xDEAD_BEEF. Write 0x1122_3344 to offset 0x00 with `sel` = 4'b0101 → reads back 0xDE22_BE44.
- **Decode limits.** Write to 0x3000_0200 → acked, reads 0. Access 0x3100_0000 → no ack within 8 cycles and no state change.
- **Bus timing.** Hold `stb` high for 3 transfers → `ack` pattern is 0,1,0,1,0,1 with no back-to-back acks. Drop `stb` in the request cycle → no ack and no write.
- **Reset mid-write.** Assert reset in the accept cycle → no ack follows and all registers hold their reset values.
